// File: rtl/reg_file_issue.sv
// Serial operand-issue / writeback stage around an external 8-bit ALU.
// One instruction in flight: IDLE accepts, EXEC samples the ALU, WB retires.
module reg_file_issue #(
    parameter int DATA_W    = 8,
    parameter int REG_COUNT = 4,
    parameter bit R0_ZERO   = 1'b1
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Instr_Valid,
    input  logic [15:0]       i_Instr,
    output logic              o_Instr_Ready,
    output logic [DATA_W-1:0] o_Val_1,
    output logic [DATA_W-1:0] o_Val_2,
    output logic [2:0]        o_ALU_Op,
    input  logic [DATA_W-1:0] i_Result,
    input  logic              i_Overflow,
    input  logic              i_Zero_Flag,
    output logic              o_Flag_Z,
    output logic              o_Flag_V,
    output logic              o_Retire,
    output logic              o_Illegal,
    input  logic [1:0]        i_Dbg_Addr,
    output logic [DATA_W-1:0] o_Dbg_Data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_NOP = 3'b000;

    state_t            state_q, state_d;
    logic [1:0]        rd_q, rd_d;
    logic [DATA_W-1:0] val1_q, val1_d;
    logic [DATA_W-1:0] val2_q, val2_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              ovf_q, ovf_d;
    logic              zf_q, zf_d;
    logic              flag_z_q, flag_z_d;
    logic              flag_v_q, flag_v_d;
    logic              retire_q, retire_d;
    logic              illegal_q, illegal_d;
    logic [DATA_W-1:0] gpr_q [REG_COUNT];
    logic [DATA_W-1:0] gpr_d [REG_COUNT];
    logic [DATA_W-1:0] gpr_rd [REG_COUNT];

    logic [2:0]        in_op;
    logic              in_imm;
    logic [1:0]        in_rd;
    logic [1:0]        in_rs1;
    logic [1:0]        in_rs2;
    logic [DATA_W-1:0] in_imm8;

    assign in_op   = i_Instr[15:13];
    assign in_imm  = i_Instr[12];
    assign in_rd   = i_Instr[11:10];
    assign in_rs1  = i_Instr[9:8];
    assign in_rs2  = i_Instr[1:0];
    assign in_imm8 = i_Instr[7:0];

    // Architectural view of the register file: r0 is hard-wired to zero when enabled.
    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            gpr_rd[i] = (R0_ZERO && i == 0) ? '0 : gpr_q[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        val1_d    = val1_q;
        val2_d    = val2_q;
        op_d      = op_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        zf_d      = zf_q;
        flag_z_d  = flag_z_q;
        flag_v_d  = flag_v_q;
        retire_d  = 1'b0;
        illegal_d = 1'b0;
        gpr_d     = gpr_q;

        case (state_q)
            S_IDLE: begin
                if (i_Instr_Valid) begin
                    if (in_op == OP_ADD || in_op == OP_SUB) begin
                        rd_d    = in_rd;
                        val1_d  = gpr_rd[in_rs1];
                        val2_d  = in_imm ? in_imm8 : gpr_rd[in_rs2];
                        op_d    = in_op;
                        state_d = S_EXEC;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                res_d   = i_Result;
                ovf_d   = i_Overflow;
                zf_d    = i_Zero_Flag;
                op_d    = OP_NOP;
                state_d = S_WB;
            end
            S_WB: begin
                // Flags still update when an r0 write is discarded.
                if (!(R0_ZERO && rd_q == 2'd0)) begin
                    gpr_d[rd_q] = res_q;
                end
                flag_z_d = zf_q;
                flag_v_d = ovf_q;
                retire_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q   <= S_IDLE;
            rd_q      <= '0;
            val1_q    <= '0;
            val2_q    <= '0;
            op_q      <= OP_NOP;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            zf_q      <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_v_q  <= 1'b0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            val1_q    <= val1_d;
            val2_q    <= val2_d;
            op_q      <= op_d;
            res_q     <= res_d;
            ovf_q     <= ovf_d;
            zf_q      <= zf_d;
            flag_z_q  <= flag_z_d;
            flag_v_q  <= flag_v_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
            for (int i = 0; i < REG_COUNT; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
        end
    end

    assign o_Instr_Ready = (state_q == S_IDLE);
    assign o_Val_1       = val1_q;
    assign o_Val_2       = val2_q;
    assign o_ALU_Op      = op_q;
    assign o_Flag_Z      = flag_z_q;
    assign o_Flag_V      = flag_v_q;
    assign o_Retire      = retire_q;
    assign o_Illegal     = illegal_q;
    assign o_Dbg_Data    = gpr_rd[i_Dbg_Addr];

endmodule

// File: tb/tb_reg_file_issue.sv
// Directed bench for reg_file_issue with a behavioural 8-bit ADD/SUB ALU model.
module tb_reg_file_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [15:0] instr;
    logic        ready;
    logic [7:0]  val1, val2;
    logic [2:0]  alu_op;
    logic [7:0]  alu_res;
    logic        alu_ovf, alu_z;
    logic        flag_z, flag_v;
    logic        retire, illegal;
    logic [1:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_file_issue dut (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_Instr_Valid (valid),
        .i_Instr       (instr),
        .o_Instr_Ready (ready),
        .o_Val_1       (val1),
        .o_Val_2       (val2),
        .o_ALU_Op      (alu_op),
        .i_Result      (alu_res),
        .i_Overflow    (alu_ovf),
        .i_Zero_Flag   (alu_z),
        .o_Flag_Z      (flag_z),
        .o_Flag_V      (flag_v),
        .o_Retire      (retire),
        .o_Illegal     (illegal),
        .i_Dbg_Addr    (dbg_addr),
        .o_Dbg_Data    (dbg_data)
    );

    // ALU: SUB for opcode 010, ADD otherwise; signed overflow from operand/result signs.
    always_comb begin
        if (alu_op == 3'b010) begin
            alu_res = val1 - val2;
            alu_ovf = (val1[7] != val2[7]) && (alu_res[7] != val1[7]);
        end else begin
            alu_res = val1 + val2;
            alu_ovf = (val1[7] == val2[7]) && (alu_res[7] != val1[7]);
        end
        alu_z = (alu_res == 8'h00);
    end

    function automatic logic [15:0] mk(input logic [2:0] op, input logic imm,
                                       input logic [1:0] rd, input logic [1:0] rs1,
                                       input logic [7:0] low);
        return {op, imm, rd, rs1, low};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic peek(input logic [1:0] idx, input logic [7:0] exp, input string tag);
        dbg_addr = idx;
        #1;
        check(tag, {24'd0, dbg_data}, {24'd0, exp});
    endtask

    // Present one instruction for the accept edge, then run EXEC and WB;
    // returns just after the WB edge, where retire should be high.
    task automatic run_instr(input logic [15:0] ins);
        valid = 1'b1;
        instr = ins;
        tick();
        valid = 1'b0;
        instr = 16'h0000;
        tick();
        tick();
    endtask

    initial begin
        rst      = 1'b1;
        valid    = 1'b0;
        instr    = 16'h0000;
        dbg_addr = 2'd0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_ready",   {31'd0, ready},   32'd1);
        check("rst_retire",  {31'd0, retire},  32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_val1",    {24'd0, val1},    32'd0);
        check("rst_val2",    {24'd0, val2},    32'd0);
        check("rst_op",      {29'd0, alu_op},  32'd0);
        check("rst_zv",      {30'd0, flag_z, flag_v}, 32'd0);
        peek(2'd1, 8'h00, "rst_r1");

        // 1: ADD imm r1 = r0 + 0x05
        valid = 1'b1;
        instr = mk(3'b001, 1'b1, 2'd1, 2'd0, 8'h05);
        tick();
        valid = 1'b0;
        check("t1_exec_val1",  {24'd0, val1},   32'h00);
        check("t1_exec_val2",  {24'd0, val2},   32'h05);
        check("t1_exec_op",    {29'd0, alu_op}, 32'd1);
        check("t1_exec_ready", {31'd0, ready},  32'd0);
        tick();
        check("t1_wb_op",      {29'd0, alu_op}, 32'd0);
        check("t1_wb_retire",  {31'd0, retire}, 32'd0);
        tick();
        check("t1_retire",     {31'd0, retire}, 32'd1);
        check("t1_ready",      {31'd0, ready},  32'd1);
        peek(2'd1, 8'h05, "t1_r1");
        check("t1_z",          {31'd0, flag_z}, 32'd0);
        check("t1_v",          {31'd0, flag_v}, 32'd0);
        tick();
        check("t1_retire_end", {31'd0, retire}, 32'd0);

        // 2: r2 = 0x7F, r3 = r2 + 1 overflows
        run_instr(mk(3'b001, 1'b1, 2'd2, 2'd0, 8'h7F));
        peek(2'd2, 8'h7F, "t2_r2");
        run_instr(mk(3'b001, 1'b1, 2'd3, 2'd2, 8'h01));
        check("t2_retire", {31'd0, retire}, 32'd1);
        peek(2'd3, 8'h80, "t2_r3");
        check("t2_v", {31'd0, flag_v}, 32'd1);
        check("t2_z", {31'd0, flag_z}, 32'd0);

        // 3: SUB reg r1 = r1 - r1
        valid = 1'b1;
        instr = mk(3'b010, 1'b0, 2'd1, 2'd1, 8'h01);
        tick();
        valid = 1'b0;
        check("t3_exec_val1", {24'd0, val1},   32'h05);
        check("t3_exec_val2", {24'd0, val2},   32'h05);
        check("t3_exec_op",   {29'd0, alu_op}, 32'd2);
        tick();
        tick();
        check("t3_retire", {31'd0, retire}, 32'd1);
        peek(2'd1, 8'h00, "t3_r1");
        check("t3_z", {31'd0, flag_z}, 32'd1);
        check("t3_v", {31'd0, flag_v}, 32'd0);

        // 4: write to r0 is dropped, flags still update
        run_instr(mk(3'b001, 1'b1, 2'd0, 2'd0, 8'h80));
        check("t4_retire", {31'd0, retire}, 32'd1);
        peek(2'd0, 8'h00, "t4_r0");
        check("t4_z", {31'd0, flag_z}, 32'd0);
        check("t4_v", {31'd0, flag_v}, 32'd0);

        // 5: unsupported opcode
        tick();
        valid = 1'b1;
        instr = mk(3'b011, 1'b1, 2'd2, 2'd0, 8'h44);
        tick();
        valid = 1'b0;
        check("t5_illegal", {31'd0, illegal}, 32'd1);
        check("t5_retire",  {31'd0, retire},  32'd0);
        check("t5_ready",   {31'd0, ready},   32'd1);
        check("t5_op",      {29'd0, alu_op},  32'd0);
        tick();
        check("t5_illegal_end", {31'd0, illegal}, 32'd0);
        check("t5_retire_end",  {31'd0, retire},  32'd0);
        peek(2'd2, 8'h7F, "t5_r2");
        peek(2'd3, 8'h80, "t5_r3");
        check("t5_zv", {30'd0, flag_z, flag_v}, 32'd0);

        // 6: valid held for two instructions, then reset during EXEC
        valid = 1'b1;
        instr = mk(3'b001, 1'b1, 2'd1, 2'd0, 8'h11);
        tick();
        instr = mk(3'b001, 1'b1, 2'd2, 2'd0, 8'h22);
        check("t6_a_ready", {31'd0, ready}, 32'd0);
        tick();
        check("t6_a_wb_val2", {24'd0, val2}, 32'h11);
        check("t6_a_wb_ready", {31'd0, ready}, 32'd0);
        tick();
        check("t6_a_retire", {31'd0, retire}, 32'd1);
        check("t6_a_ready1", {31'd0, ready}, 32'd1);
        peek(2'd1, 8'h11, "t6_r1");
        tick();
        valid = 1'b0;
        check("t6_b_ready", {31'd0, ready}, 32'd0);
        check("t6_b_val2", {24'd0, val2}, 32'h22);
        tick();
        check("t6_b_wb_retire", {31'd0, retire}, 32'd0);
        tick();
        check("t6_b_retire", {31'd0, retire}, 32'd1);
        peek(2'd2, 8'h22, "t6_r2");

        tick();
        valid = 1'b1;
        instr = mk(3'b001, 1'b1, 2'd3, 2'd0, 8'h33);
        tick();
        valid = 1'b0;
        check("t6_c_exec", {29'd0, alu_op}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_ready",  {31'd0, ready},  32'd1);
        check("t6_rst_retire", {31'd0, retire}, 32'd0);
        check("t6_rst_op",     {29'd0, alu_op}, 32'd0);
        peek(2'd1, 8'h00, "t6_rst_r1");
        peek(2'd2, 8'h00, "t6_rst_r2");
        tick();
        check("t6_post_retire", {31'd0, retire}, 32'd0);
        peek(2'd3, 8'h00, "t6_post_r3");
        check("t6_post_zv", {30'd0, flag_z, flag_v}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
